uart_tx_framer: RTL and testbench

//  Serialises bytes into UART frames: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/baud_tick_gen.sv | 31 +++
 rtl/uart_tx_framer.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_framer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART frame definitions for the transmit framer and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam int unsigned DataBitsMax = 9;

  localparam logic LineIdle   = 1'b1;
  localparam logic StartLevel = 1'b0;
  localparam logic StopLevel  = 1'b1;

  // Data narrower than DataBitsMax is zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [DataBitsMax-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Turns an asynchronous baud square wave into a one-cycle tick on each rising edge.
// Reset is synchronous and active low.
module baud_tick_gen (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic baud_i,
  output logic tick_o
);

  logic [2:0] sync_d, sync_q;
  logic       tick_d, tick_q;

  always_comb begin
    sync_d = {sync_q[1:0], baud_i};
    // sync_q[1] is the second synchroniser stage, sync_q[2] its delayed copy.
    tick_d = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_tx_framer.sv
// Byte-to-UART-frame serialiser with a one-entry holding buffer.
// Bit timing comes from baud_clk edges, which are sampled as data, never used as a clock.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned     CntW      = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] DataBitsC = CntW'(DATA_BITS);
  localparam logic [1:0]      StopBitsC = 2'(STOP_BITS);

  logic tick;

  baud_tick_gen u_baud_tick_gen (
    .clk_i  (clk_in),
    .rst_ni (reset),
    .baud_i (baud_clk),
    .tick_o (tick)
  );

  uart_tx_state_e       state_d, state_q;
  logic [DATA_BITS-1:0] shreg_d, shreg_q;
  logic [DATA_BITS-1:0] buf_d, buf_q;
  logic                 buf_full_d, buf_full_q;
  logic                 par_d, par_q;
  logic [CntW-1:0]      bit_cnt_d, bit_cnt_q;
  logic [1:0]           stop_cnt_d, stop_cnt_q;
  logic                 tx_d, tx_q;
  logic                 tx_done_d, tx_done_q;
  logic                 load;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = LineIdle;
        if (tick && buf_full_q) begin
          load    = 1'b1;
          tx_d    = StartLevel;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = CntW'(1);
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q < DataBitsC) begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end else if (PARITY_EN) begin
            tx_d    = par_q;
            state_d = PARITY;
          end else begin
            tx_d       = StopLevel;
            stop_cnt_d = 2'd1;
            state_d    = STOP;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          tx_d       = StopLevel;
          stop_cnt_d = 2'd1;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt_q < StopBitsC) begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end else begin
            tx_done_d = 1'b1;
            // A waiting byte starts immediately so frames run without an idle bit.
            if (buf_full_q) begin
              load    = 1'b1;
              tx_d    = StartLevel;
              state_d = START;
            end else begin
              tx_d    = LineIdle;
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        tx_d    = LineIdle;
        state_d = IDLE;
      end
    endcase

    if (load) begin
      shreg_d    = buf_q;
      par_d      = parity_bit(DataBitsMax'(buf_q), PARITY_ODD);
      buf_full_d = 1'b0;
    end

    if (in_valid && !buf_full_q) begin
      buf_d      = in_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      tx_q       <= LineIdle;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign in_ready = ~buf_full_q;
  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench: 8N1, 8E2 and 8O1 framers sharing one baud source; tx sampled one cycle after
// each locally modelled baud tick.
module tb_uart_tx_framer;

  logic       clk;
  logic       reset;
  logic       baud;
  logic [2:0] valid_v, ready_v, tx_v, busy_v, done_v;
  logic [7:0] data_v [3];

  int n_checks  = 0;
  int n_pass    = 0;
  int baud_half = 8;
  int last_gap  = 0;
  int done_cnt0 = 0;

  // Expected tick timing: two-flop synchroniser, delayed copy, registered rising edge.
  logic [2:0] sync_m;
  logic       tick_m;

  uart_tx_framer #(
    .DATA_BITS (8), .PARITY_EN (1'b0), .PARITY_ODD (1'b0), .STOP_BITS (1)
  ) u_dut_8n1 (
    .clk_in (clk), .reset (reset), .baud_clk (baud), .in_data (data_v[0]),
    .in_valid (valid_v[0]), .in_ready (ready_v[0]), .tx (tx_v[0]), .busy (busy_v[0]),
    .tx_done (done_v[0])
  );

  uart_tx_framer #(
    .DATA_BITS (8), .PARITY_EN (1'b1), .PARITY_ODD (1'b0), .STOP_BITS (2)
  ) u_dut_8e2 (
    .clk_in (clk), .reset (reset), .baud_clk (baud), .in_data (data_v[1]),
    .in_valid (valid_v[1]), .in_ready (ready_v[1]), .tx (tx_v[1]), .busy (busy_v[1]),
    .tx_done (done_v[1])
  );

  uart_tx_framer #(
    .DATA_BITS (8), .PARITY_EN (1'b1), .PARITY_ODD (1'b1), .STOP_BITS (1)
  ) u_dut_8o1 (
    .clk_in (clk), .reset (reset), .baud_clk (baud), .in_data (data_v[2]),
    .in_valid (valid_v[2]), .in_ready (ready_v[2]), .tx (tx_v[2]), .busy (busy_v[2]),
    .tx_done (done_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    baud = 1'b0;
    forever begin
      repeat (baud_half) @(negedge clk);
      baud = ~baud;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_m <= '0;
      tick_m <= 1'b0;
    end else begin
      sync_m <= {sync_m[1:0], baud};
      tick_m <= sync_m[1] & ~sync_m[2];
    end
  end

  always_ff @(posedge clk) begin
    if (done_v[0]) done_cnt0 <= done_cnt0 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Returns one cycle after the next modelled tick, when the new tx bit is visible.
  task automatic wait_tick();
    int cnt  = 0;
    bit seen = 1'b0;
    while (!seen && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (tick_m) seen = 1'b1;
    end
    if (!seen) check("tick_seen", 32'(tick_m), 32'd1);
    last_gap = cnt + 1;
    @(negedge clk);
  endtask

  task automatic get_bit(input int d, output logic b);
    wait_tick();
    b = tx_v[d];
  endtask

  task automatic send(input int d, input logic [7:0] data);
    valid_v[d] = 1'b1;
    data_v[d]  = data;
    @(negedge clk);
    valid_v[d] = 1'b0;
  endtask

  task automatic expect_start(input int d, input string tag);
    logic b;
    b = 1'b1;
    for (int i = 0; i < 8 && b; i++) get_bit(d, b);
    check({tag, "_start"}, 32'(b), 32'd0);
  endtask

  task automatic check_bits(input int d, input string tag, input logic [7:0] data,
                            input int lo, input int hi);
    logic b;
    for (int i = lo; i <= hi; i++) begin
      get_bit(d, b);
      check($sformatf("%s_d%0d", tag, i), 32'(b), 32'(data[i]));
    end
  endtask

  logic b;
  int   d0;

  initial begin
    reset   = 1'b0;
    valid_v = '0;
    for (int i = 0; i < 3; i++) data_v[i] = 8'h00;

    // Reset held with a byte offered: nothing may be taken.
    valid_v[0] = 1'b1;
    data_v[0]  = 8'hAA;
    repeat (4) @(negedge clk);
    check("rst_tx", 32'(tx_v[0]), 32'd1);
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_ready", 32'(ready_v[0]), 32'd1);
    check("rst_done", 32'(done_v[0]), 32'd0);
    valid_v[0] = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    check("rst_no_handshake", 32'(ready_v[0]), 32'd1);
    wait_tick();
    check("rst_idle_tx", 32'(tx_v[0]), 32'd1);
    check("rst_idle_busy", 32'(busy_v[0]), 32'd0);

    // 0xA5, 8N1: 0,1,0,1,0,0,1,0,1,1.
    d0 = done_cnt0;
    send(0, 8'hA5);
    expect_start(0, "a5");
    check("a5_busy", 32'(busy_v[0]), 32'd1);
    check_bits(0, "a5", 8'hA5, 0, 7);
    check("a5_gap", 32'(last_gap), 32'd16);
    get_bit(0, b);
    check("a5_stop", 32'(b), 32'd1);
    check("a5_done_early", 32'(done_v[0]), 32'd0);
    wait_tick();
    check("a5_done", 32'(done_v[0]), 32'd1);
    check("a5_busy_fall", 32'(busy_v[0]), 32'd0);
    check("a5_idle_tx", 32'(tx_v[0]), 32'd1);
    repeat (3) @(negedge clk);
    check("a5_done_once", 32'(done_cnt0 - d0), 32'd1);

    // Back-to-back 0x55 then 0x0F; later data offered while full must be ignored.
    send(0, 8'h55);
    expect_start(0, "bb1");
    check_bits(0, "bb1", 8'h55, 0, 2);
    send(0, 8'h0F);
    check("bb_ready_low", 32'(ready_v[0]), 32'd0);
    valid_v[0] = 1'b1;
    data_v[0]  = 8'hFF;
    check_bits(0, "bb1", 8'h55, 3, 4);
    data_v[0] = 8'hF0;
    check_bits(0, "bb1", 8'h55, 5, 5);
    valid_v[0] = 1'b0;
    check_bits(0, "bb1", 8'h55, 6, 7);
    get_bit(0, b);
    check("bb1_stop", 32'(b), 32'd1);
    check("bb_ready_still_low", 32'(ready_v[0]), 32'd0);
    get_bit(0, b);
    check("bb2_start", 32'(b), 32'd0);
    check("bb1_done", 32'(done_v[0]), 32'd1);
    check("bb_busy_held", 32'(busy_v[0]), 32'd1);
    check("bb_ready_drained", 32'(ready_v[0]), 32'd1);
    check_bits(0, "bb2", 8'h0F, 0, 7);
    get_bit(0, b);
    check("bb2_stop", 32'(b), 32'd1);
    wait_tick();
    check("bb2_done", 32'(done_v[0]), 32'd1);
    check("bb2_busy_fall", 32'(busy_v[0]), 32'd0);
    wait_tick();
    check("bb_no_third_tx", 32'(tx_v[0]), 32'd1);
    check("bb_no_third_busy", 32'(busy_v[0]), 32'd0);

    // Even parity, two stop bits: 0x07 -> parity 1.
    send(1, 8'h07);
    expect_start(1, "pe");
    check_bits(1, "pe", 8'h07, 0, 7);
    get_bit(1, b);
    check("pe_parity", 32'(b), 32'd1);
    get_bit(1, b);
    check("pe_stop1", 32'(b), 32'd1);
    check("pe_done_stop1", 32'(done_v[1]), 32'd0);
    get_bit(1, b);
    check("pe_stop2", 32'(b), 32'd1);
    check("pe_done_stop2", 32'(done_v[1]), 32'd0);
    check("pe_busy_stop2", 32'(busy_v[1]), 32'd1);
    wait_tick();
    check("pe_done", 32'(done_v[1]), 32'd1);
    check("pe_busy_fall", 32'(busy_v[1]), 32'd0);

    // Odd parity, one stop bit: 0x07 -> parity 0.
    send(2, 8'h07);
    expect_start(2, "po");
    check_bits(2, "po", 8'h07, 0, 7);
    get_bit(2, b);
    check("po_parity", 32'(b), 32'd0);
    get_bit(2, b);
    check("po_stop", 32'(b), 32'd1);
    wait_tick();
    check("po_done", 32'(done_v[2]), 32'd1);

    // Reset during data bit 3 with a byte buffered.
    send(0, 8'h3C);
    expect_start(0, "ra");
    check_bits(0, "ra", 8'h3C, 0, 3);
    send(0, 8'h99);
    check("ra_buffered", 32'(ready_v[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ra_tx", 32'(tx_v[0]), 32'd1);
    check("ra_busy", 32'(busy_v[0]), 32'd0);
    check("ra_ready", 32'(ready_v[0]), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      get_bit(0, b);
      check($sformatf("ra_idle%0d", i), 32'(b), 32'd1);
    end
    check("ra_idle_busy", 32'(busy_v[0]), 32'd0);
    send(0, 8'hC3);
    expect_start(0, "rb");
    check_bits(0, "rb", 8'hC3, 0, 7);
    get_bit(0, b);
    check("rb_stop", 32'(b), 32'd1);
    wait_tick();
    check("rb_done", 32'(done_v[0]), 32'd1);

    // Baud period 16 -> 32 mid-frame.
    send(0, 8'h96);
    expect_start(0, "sw");
    check_bits(0, "sw", 8'h96, 0, 2);
    baud_half = 16;
    check_bits(0, "sw", 8'h96, 3, 7);
    check("sw_gap", 32'(last_gap), 32'd32);
    get_bit(0, b);
    check("sw_stop", 32'(b), 32'd1);
    wait_tick();
    check("sw_done", 32'(done_v[0]), 32'd1);
    check("sw_busy_fall", 32'(busy_v[0]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
